bram_axistream_fifo: RTL and testbench

BRAM_AXISTREAM_FIFO -- requirements
Module: bram_axistream_fifo

---
 rtl/bram_axistream_fifo_pkg.sv | 19 +
 rtl/bram_axistream_fifo_sdp_bram.sv | 53 +++++
 rtl/bram_axistream_fifo.sv | 143 ++++++++++++++
 tb/tb_bram_axistream_fifo.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bram_axistream_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bram_axistream_fifo_pkg                                    |
// | Brief   : Shared defaults and width helpers for the BRAM AXI-Stream   |
// |           FIFO slice.                                                |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package bram_axistream_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 3;

  // Occupancy counter must represent 0..2**addr_width inclusive.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_axistream_fifo_sdp_bram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sdp_bram                                                   |
// | Brief   : Simple dual-port RAM, one synchronous write port and one   |
// |           enable-gated registered read port (read data holds when    |
// |           the read enable is low).                                   |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module sdp_bram
  import bram_axistream_fifo_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Write port: storage is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port next value: fetch on enable, otherwise hold the last word.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  // Read port output register.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/bram_axistream_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bram_axistream_fifo                                        |
// | Brief   : AXI-Stream FIFO on a registered-read BRAM followed by a    |
// |           head-word output register. Full throughput, registered     |
// |           src_tready. Optional tlast carriage is enabled by defining |
// |           BRAM_AXISTREAM_FIFO_TLAST_EN.                              |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module bram_axistream_fifo
  import bram_axistream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  src_tvalid,
  output logic                  src_tready,
  input  logic [DATA_WIDTH-1:0] src_tdata,
  input  logic                  src_tlast,
  output logic                  dest_tvalid,
  input  logic                  dest_tready,
  output logic [DATA_WIDTH-1:0] dest_tdata,
  output logic                  dest_tlast,
  output logic [ADDR_WIDTH:0]   data_cnt
);

  localparam int CNT_W = cnt_width(ADDR_WIDTH);
`ifdef BRAM_AXISTREAM_FIFO_TLAST_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      data_cnt_q, data_cnt_d;
  logic                  bram_vld_q, bram_vld_d;
  logic                  out_vld_q, out_vld_d;
  logic [MEM_W-1:0]      out_word_q, out_word_d;

  logic [MEM_W-1:0]      wr_word;
  logic [MEM_W-1:0]      rd_word;
  logic [CNT_W-1:0]      mem_cnt;
  logic                  push;
  logic                  pop;
  logic                  out_load;
  logic                  rd_en;

`ifdef BRAM_AXISTREAM_FIFO_TLAST_EN
  assign wr_word    = {src_tlast, src_tdata};
  assign dest_tlast = out_word_q[DATA_WIDTH];
`else
  logic unused_src_tlast;
  assign unused_src_tlast = src_tlast;
  assign wr_word    = src_tdata;
  assign dest_tlast = 1'b0;
`endif

  // Handshakes and pipeline control. Words still in the RAM are the
  // accepted total minus those parked in the read and head registers.
  // Ready depends only on the registered count, so a same-cycle pop
  // never frees space for a push.
  always_comb begin
    src_tready = ~data_cnt_q[CNT_W-1];
    push       = src_tvalid & ~data_cnt_q[CNT_W-1];
    pop        = out_vld_q & dest_tready;
    out_load   = bram_vld_q & (~out_vld_q | pop);
    mem_cnt    = data_cnt_q - CNT_W'(out_vld_q) - CNT_W'(bram_vld_q);
    rd_en      = (mem_cnt != '0) & (~bram_vld_q | out_load);
  end

  // Next-state for pointers, occupancy and the two pipeline stages.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_cnt_d = data_cnt_q;
    bram_vld_d = bram_vld_q;
    out_vld_d  = out_vld_q;
    out_word_d = out_word_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
    case ({push, pop})
      2'b10:   data_cnt_d = data_cnt_q + CNT_W'(1);
      2'b01:   data_cnt_d = data_cnt_q - CNT_W'(1);
      default: data_cnt_d = data_cnt_q;
    endcase
    if (rd_en) begin
      bram_vld_d = 1'b1;
    end else if (out_load) begin
      bram_vld_d = 1'b0;
    end
    if (out_load) begin
      out_vld_d  = 1'b1;
      out_word_d = rd_word;
    end else if (pop) begin
      out_vld_d  = 1'b0;
    end
  end

  // State registers; reset discards everything, including any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_cnt_q <= '0;
      bram_vld_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_word_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_cnt_q <= data_cnt_d;
      bram_vld_q <= bram_vld_d;
      out_vld_q  <= out_vld_d;
      out_word_q <= out_word_d;
    end
  end

  sdp_bram #(
    .WIDTH      (MEM_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~rst),
    .waddr (wr_ptr_q),
    .wdata (wr_word),
    .re    (rd_en & ~rst),
    .raddr (rd_ptr_q),
    .rdata (rd_word)
  );

  assign dest_tvalid = out_vld_q;
  assign dest_tdata  = out_word_q[DATA_WIDTH-1:0];
  assign data_cnt    = data_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_axistream_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_bram_axistream_fifo                                     |
// | Brief   : Self-checking bench for bram_axistream_fifo (8-bit data,   |
// |           depth 8) against a queue-based reference model.            |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_bram_axistream_fifo;

  localparam int DEPTH = 8;
`ifdef BRAM_AXISTREAM_FIFO_TLAST_EN
  localparam bit TL_EN = 1'b1;
`else
  localparam bit TL_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       src_tvalid;
  logic       src_tready;
  logic [7:0] src_tdata;
  logic       src_tlast;
  logic       dest_tvalid;
  logic       dest_tready;
  logic [7:0] dest_tdata;
  logic       dest_tlast;
  logic [3:0] data_cnt;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [8:0] q[$];
  int         stall_run = 0;
  bit         popped_now = 1'b0;
  logic [8:0] last_popped = '0;
  int         steady_lvl = 0;

  bram_axistream_fifo #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src_tvalid  (src_tvalid),
    .src_tready  (src_tready),
    .src_tdata   (src_tdata),
    .src_tlast   (src_tlast),
    .dest_tvalid (dest_tvalid),
    .dest_tready (dest_tready),
    .dest_tdata  (dest_tdata),
    .dest_tlast  (dest_tlast),
    .data_cnt    (data_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: record the handshakes visible before the edge, advance,
  // update the queue model and compare the DUT against it.
  task automatic tick();
    bit         do_push, do_pop, was_stall, in_rst;
    logic [8:0] in_word, head_word, exp_word;
    in_rst    = (rst === 1'b1);
    do_push   = (src_tvalid === 1'b1) && (q.size() < DEPTH);
    do_pop    = (dest_tvalid === 1'b1) && (dest_tready === 1'b1);
    was_stall = (dest_tvalid === 1'b1) && (dest_tready === 1'b0);
    in_word   = {(TL_EN ? src_tlast : 1'b0), src_tdata};
    head_word = {dest_tlast, dest_tdata};
    @(posedge clk);
    #1;
    popped_now = 1'b0;
    if (in_rst) begin
      q.delete();
      chk("rst_cnt",   32'(data_cnt), 32'd0);
      chk("rst_valid", 32'(dest_tvalid), 32'd0);
      chk("rst_ready", 32'(src_tready), 32'd1);
      chk("rst_data",  32'(dest_tdata), 32'd0);
      chk("rst_last",  32'(dest_tlast), 32'd0);
    end else begin
      if (do_pop) begin
        popped_now  = 1'b1;
        last_popped = head_word;
        chk("pop_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          exp_word = q.pop_front();
          chk("pop_word", 32'(head_word), 32'(exp_word));
        end
      end
      if (do_push) q.push_back(in_word);
      if (was_stall) begin
        chk("hold_valid", 32'(dest_tvalid), 32'd1);
        chk("hold_word",  32'({dest_tlast, dest_tdata}), 32'(head_word));
      end
    end
    chk("data_cnt",    32'(data_cnt), 32'(q.size()));
    chk("src_tready",  32'(src_tready), 32'(q.size() < DEPTH));
    chk("cnt_max",     32'(data_cnt <= 4'd8), 32'd1);
    chk("valid_empty", 32'(dest_tvalid && (q.size() == 0)), 32'd0);
    if (q.size() != 0 && dest_tvalid !== 1'b1) stall_run++;
    else stall_run = 0;
    chk("head_latency", 32'(stall_run <= 2), 32'd1);
  endtask

  task automatic drain(input string tag);
    src_tvalid  = 1'b0;
    dest_tready = 1'b1;
    for (int k = 0; k < 40 && (q.size() != 0 || dest_tvalid === 1'b1); k++) tick();
    chk({tag, "_empty"}, 32'(q.size()), 32'd0);
    chk({tag, "_valid"}, 32'(dest_tvalid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; src_tvalid = 1'b0; src_tdata = '0; src_tlast = 1'b0; dest_tready = 1'b0;
    #1;
    tick();
    tick();
    rst = 1'b0;

    // Single word latency and content.
    src_tvalid = 1'b1; src_tdata = 8'h11; src_tlast = 1'b1; dest_tready = 1'b0;
    tick();
    src_tvalid = 1'b0; src_tlast = 1'b0;
    tick();
    tick();
    chk("first_valid", 32'(dest_tvalid), 32'd1);
    chk("first_data",  32'(dest_tdata), 32'h11);
    chk("first_last",  32'(dest_tlast), 32'(TL_EN));
    chk("first_cnt",   32'(data_cnt), 32'd1);
    drain("first_drain");

    // Fill to capacity, then offer one more word.
    dest_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      src_tvalid = 1'b1; src_tdata = 8'(i); src_tlast = i[0];
      tick();
    end
    chk("full_cnt",   32'(data_cnt), 32'd8);
    chk("full_ready", 32'(src_tready), 32'd0);
    src_tdata = 8'h99;
    for (int i = 0; i < 3; i++) tick();
    chk("full_reject", 32'(data_cnt), 32'd8);
    drain("full_drain");

    // Continuous streaming.
    src_tvalid = 1'b1; dest_tready = 1'b1; src_tlast = 1'b0;
    for (int i = 0; i < 32; i++) begin
      src_tdata = 8'(8'h20 + i);
      src_tlast = (i % 4 == 3);
      tick();
      if (i == 4) steady_lvl = q.size();
      if (i >= 4) begin
        chk("tput_pop",   32'(popped_now), 32'd1);
        chk("tput_level", 32'(q.size()), 32'(steady_lvl));
      end
    end
    drain("stream_drain");

    // Reset while holding five words; handshakes during reset are ignored.
    dest_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      src_tvalid = 1'b1; src_tdata = 8'(8'h50 + i);
      tick();
    end
    chk("pre_rst_cnt", 32'(data_cnt), 32'd5);
    rst = 1'b1; src_tdata = 8'h5A; dest_tready = 1'b1;
    tick();
    rst = 1'b0; dest_tready = 1'b0;
    src_tvalid = 1'b1; src_tdata = 8'hA5; src_tlast = 1'b0;
    tick();
    src_tvalid = 1'b0; dest_tready = 1'b1;
    for (int k = 0; k < 10 && !popped_now; k++) tick();
    chk("rst_first_pop", 32'(popped_now), 32'd1);
    chk("rst_first_word", 32'(last_popped[7:0]), 32'hA5);
    drain("rst_drain");

    // Random valid/ready stalls.
    for (int i = 0; i < 1000; i++) begin
      src_tvalid  = $urandom_range(1, 0) == 1;
      src_tdata   = 8'($urandom);
      src_tlast   = $urandom_range(1, 0) == 1;
      dest_tready = $urandom_range(3, 0) != 0;
      tick();
    end
    drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
